ag_h: RTL and testbench



---
 rtl/ag_h.sv | 126 ++++++++++++
 tb/tb_ag_h.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ag_h.sv
// Row-major address generator for the LSTM hidden-state (h) buffer.
// One address per sys_clk cycle across an M x M buffer, then a one-cycle done pulse.
module ag_h #(
  parameter int FEATURE_BITS = 4,
  parameter int M            = 9
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      done,
  output logic [2*FEATURE_BITS-1:0] address
);

  localparam int AW = 2 * FEATURE_BITS;

  localparam logic [FEATURE_BITS-1:0] IDX_LAST = FEATURE_BITS'(M - 1);
  localparam logic [AW-1:0]           ROW_STEP = AW'(M);

  // Elaboration-time guards: the counters and the address must hold every index.
  if (M < 2) begin : g_err_m_small
    $error("ag_h: M (%0d) must be at least 2", M);
  end
  if (longint'(M) > (longint'(1) << FEATURE_BITS)) begin : g_err_m_idx
    $error("ag_h: M (%0d) exceeds 2**FEATURE_BITS (FEATURE_BITS=%0d)", M, FEATURE_BITS);
  end
  if (longint'(M) * longint'(M) > (longint'(1) << AW)) begin : g_err_m_addr
    $error("ag_h: M*M (%0d) exceeds the %0d-bit address space", M * M, AW);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [FEATURE_BITS-1:0] row;
  logic [FEATURE_BITS-1:0] col;
  logic [AW-1:0]           row_base;

  logic                    col_wrap;
  logic                    last_addr;
  logic [FEATURE_BITS-1:0] next_col;
  logic [FEATURE_BITS-1:0] next_row;
  logic [AW-1:0]           next_row_base;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    col_wrap      = 1'b0;
    last_addr     = 1'b0;
    next_col      = col;
    next_row      = row;
    next_row_base = row_base;

    col_wrap  = (col == IDX_LAST);
    last_addr = col_wrap && (row == IDX_LAST);

    if (col_wrap) begin
      next_col      = '0;
      next_row      = row + 1'b1;
      next_row_base = row_base + ROW_STEP;
    end else begin
      next_col = col + 1'b1;
    end
  end

  // The row base accumulates M per wrap, so the address is a plain add.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      address  <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          address <= '0;
          done    <= 1'b0;
          row      <= '0;
          col      <= '0;
          row_base <= '0;
          // An X on start fails this test and keeps the block idle.
          if (start == 1'b1) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (last_addr) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            row      <= next_row;
            col      <= next_col;
            row_base <= next_row_base;
            address  <= next_row_base + {{FEATURE_BITS{1'b0}}, next_col};
          end
        end

        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          address  <= '0;
          row      <= '0;
          col      <= '0;
          row_base <= '0;
        end

        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          address  <= '0;
          row      <= '0;
          col      <= '0;
          row_base <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ag_h.sv
// Randomized and directed bench for ag_h at three parameter points, checked
// against a sweep-position model (cycles elapsed since the RUN entry edge).
module tb_ag_h;

  logic sys_clk;
  logic reset_n;
  logic start;

  logic       done_a, done_b, done_c;
  logic [7:0] addr_a;
  logic [5:0] addr_b;
  logic [7:0] addr_c;

  int errors = 0;
  int checks = 0;

  ag_h #(.FEATURE_BITS(4), .M(9))  u_dut_a (.sys_clk(sys_clk), .reset_n(reset_n), .start(start), .done(done_a), .address(addr_a));
  ag_h #(.FEATURE_BITS(3), .M(4))  u_dut_b (.sys_clk(sys_clk), .reset_n(reset_n), .start(start), .done(done_b), .address(addr_b));
  ag_h #(.FEATURE_BITS(4), .M(16)) u_dut_c (.sys_clk(sys_clk), .reset_n(reset_n), .start(start), .done(done_c), .address(addr_c));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pos = -1 when idle, 0..MM-1 = address index in the sweep, MM = done cycle.
  int mm [3] = '{81, 16, 256};
  int pos[3];

  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) pos[i] <= -1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pos[i] < 0)          pos[i] <= (start === 1'b1) ? 0 : -1;
        else if (pos[i] == mm[i]) pos[i] <= -1;
        else                      pos[i] <= pos[i] + 1;
      end
    end
  end

  function automatic int exp_addr(input int i);
    if (pos[i] < 0)      return 0;
    if (pos[i] < mm[i])  return pos[i];
    return mm[i] - 1;
  endfunction

  function automatic int exp_done(input int i);
    return (pos[i] == mm[i]) ? 1 : 0;
  endfunction

  // Compare every DUT to the model on each falling edge.
  always @(negedge sys_clk) begin
    check("addr_m9",  32'(addr_a), 32'(exp_addr(0)));
    check("done_m9",  32'(done_a), 32'(exp_done(0)));
    check("addr_m4",  32'(addr_b), 32'(exp_addr(1)));
    check("done_m4",  32'(done_b), 32'(exp_done(1)));
    check("addr_m16", 32'(addr_c), 32'(exp_addr(2)));
    check("done_m16", 32'(done_c), 32'(exp_done(2)));
  end

  int cyc;
  int done_cyc[$];
  bit found;

  initial begin
    reset_n = 1'b0;
    start   = 1'bz;
    #3;
    check("reset_addr", 32'(addr_a), 32'd0);
    check("reset_done", 32'(done_a), 32'd0);
    #9;
    start   = 1'b0;
    reset_n = 1'b1;

    // Idle with start low for 10 cycles.
    repeat (10) @(negedge sys_clk);

    // Single one-cycle pulse, then stay idle long enough for every variant to finish.
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (300) @(negedge sys_clk);

    // Held start: back-to-back M=9 sweeps, done pulses 83 cycles apart.
    start = 1'b1;
    cyc   = 0;
    repeat (4 * 83) begin
      @(negedge sys_clk);
      cyc++;
      if (done_a) done_cyc.push_back(cyc);
    end
    check("held_done_count", 32'(done_cyc.size() >= 3), 32'd1);
    for (int i = 1; i < done_cyc.size(); i++)
      check("held_done_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'd83);

    // Random start activity, including toggles in mid-sweep.
    repeat (700) begin
      @(negedge sys_clk);
      start = ($urandom_range(0, 7) == 0) ? ~start : start;
    end

    // Mid-sweep asynchronous reset at address 40 of the M=9 instance.
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge sys_clk);
      if (addr_a == 8'd40) found = 1'b1;
    end
    check("reach_addr40", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_addr", 32'(addr_a), 32'd0);
    check("async_rst_done", 32'(done_a), 32'd0);
    @(negedge sys_clk);
    reset_n = 1'b1;

    // Fresh sweep with start held: done must follow within one sweep.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge sys_clk);
      if (done_a) found = 1'b1;
    end
    check("post_rst_done", 32'(found), 32'd1);

    start = 1'b0;
    repeat (300) @(negedge sys_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
